uart_rx_ovs: RTL
================

// Module: uart_rx_ovs
// PURPOSE
//   Parametrised oversampling UART receiver; successor to the fixed-format receiver.
//   Recovers async serial frames from rx_in:
//     - runtime word length 5..DATA_MAX, optional even/odd parity, 1 or 2 stop bits
//     - 3-sample majority vote at mid-bit; false-start rejection
//   Delivers each word on a valid/ready handshake with parity/framing/overrun/break status.
//   Sits between the pad synchroniser and the UART register/FIFO layer.
// PARAMETERS
//   DATA_MAX  9   widest supported word (bits); data_out width
//   OVS       16  oversampling ticks per bit (even, >=8)
//   DIV_W     16  width of the baud divider input
// PORTS
//   clk         in   1         system clock
//   rst         in   1         synchronous active-high reset
//   br_div      in   DIV_W     clk cycles per oversample tick; 0 treated as 1
//   word_len    in   4         data bits per frame, 5..DATA_MAX (others clamp)
//   parity_en   in   1         1 = parity bit present after data
//   parity_odd  in   1         1 = odd parity, 0 = even
//   stop2       in   1         1 = two stop bits
//   rx_in       in   1         serial line, idle high, async
//   data_out    out  DATA_MAX  received word, LSB = first bit, zero-extended
//   data_valid  out  1         data_out and status flags valid
//   data_ready  in   1         consumer accepts word when data_valid & data_ready
//   parity_err  out  1         parity mismatch on held word
//   frame_err   out  1         a stop bit sampled 0 on held word
//   overrun     out  1         held word overwrote an unaccepted word
//   break_det   out  1         held frame was all-zero incl. stop bit
//   busy        out  1         1 whenever state != IDLE
// BEHAVIOUR
//   - Reset: state IDLE; all outputs 0; tick and sample counters 0; 2-flop sync preset to 1.
//   - rx_in passes through a 2-flop synchroniser (rx_s); all logic uses rx_s only.
//   - Tick: div counter counts 0..br_div-1; tick pulses for one clk on wrap.
//     Counter clears on IDLE->START.
//   - Sample counter sc: 0..OVS-1, advances per tick.
//     Bit value = majority of rx_s at sc = OVS/2-1, OVS/2, OVS/2+1.
//     Vote is resolved on the OVS/2+1 tick.
//   - Config (word_len, parity_en, parity_odd, stop2) latches on IDLE->START;
//     changes mid-frame are ignored.
//   - States and transitions:
//       IDLE  -> START     on rx_s == 0
//       START -> IDLE      vote = 1 (false start): no output, no flags
//       START -> DATA      vote = 0, at sc wrap
//       DATA               shifts word_len bits LSB-first
//       DATA  -> PARITY    if parity_en
//       DATA  -> STOP      otherwise
//       PARITY -> STOP     computes err = (^data ^ pbit) != parity_odd
//       STOP               first stop voted; if stop2, stays one full period more
//                          and votes second stop
//       STOP  -> IDLE      on final stop vote tick; no wait for sc wrap, so
//                          back-to-back frames are accepted
//       STOP  -> BRK_WAIT  if break: all data bits, parity (if any) and first stop = 0
//       BRK_WAIT -> IDLE   when rx_s == 1
//   - Completion: on the final stop vote tick, data_out/flags/data_valid are registered.
//     data_valid = 1 on the next clk edge.
//     frame_err = any stop vote 0; break_det implies frame_err.
//   - Handshake: data_valid holds, data_out and flags stable, until data_valid & data_ready.
//     Then data_valid and all flags clear next cycle.
//   - Overrun: completion while data_valid=1 and data_ready=0:
//     new word and flags overwrite, overrun=1.
//   - Simultaneous completion and accept in the same cycle: new word loads,
//     data_valid stays 1, overrun=0.
//   - rst mid-frame: immediate return to IDLE; the partial word is discarded.
// TESTING
//   - br_div=4, OVS=16 (64 clk/bit), 8N1, send 0xA5
//       -> data_out=0x0A5, data_valid after ~9.5 bits (~608 clk), flags 0.
//   - 9-bit even parity, send 0x1FF with parity bit 0 -> parity_err=1, data_out=0x1FF.
//     Repeat with parity bit 1 -> parity_err=0.
//   - rx_in low for 12 clk (3 ticks) then high -> no data_valid, busy returns 0
//     within 1 bit time.
//   - Two 8N2 frames 0x11, 0x22 back-to-back, data_ready=0
//       -> data_out=0x022, overrun=1.
//     Then data_ready=1 for 1 clk -> data_valid=0, overrun=0.
//   - Line held low 20 bit times -> one word 0x000 with break_det=1, frame_err=1.
//     No further words until rx_in high and a new start bit.
//   - rst asserted in DATA mid-frame, then a clean 7E1 frame 0x55
//       -> only 0x055 delivered, no error flags.

Source files
------------

// File: rtl/uart_rx_ovs.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_ovs
//  Purpose  : Oversampling UART receiver. Recovers asynchronous serial frames
//             with a runtime word length (5..DATA_MAX), optional even/odd
//             parity and 1 or 2 stop bits. Each bit is decided by a 3-sample
//             majority vote around mid-bit. Received words are presented on a
//             valid/ready handshake together with parity, framing, overrun
//             and break status.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk         in   system clock
//    rst         in   synchronous active-high reset
//    br_div      in   clk cycles per oversample tick (0 treated as 1)
//    word_len    in   data bits per frame, clamped to 5..DATA_MAX
//    parity_en   in   parity bit present after the data bits
//    parity_odd  in   1 = odd parity, 0 = even parity
//    stop2       in   two stop bits
//    rx_in       in   serial line, idle high, asynchronous
//    data_out    out  received word, LSB first on the line, zero-extended
//    data_valid  out  data_out and status flags are valid
//    data_ready  in   consumer accepts the word when data_valid & data_ready
//    parity_err  out  parity mismatch on the held word
//    frame_err   out  a stop bit was sampled low on the held word
//    overrun     out  held word overwrote a word that was never accepted
//    break_det   out  held frame was all-zero including the first stop bit
//    busy        out  receiver is not idle
// ============================================================================
module uart_rx_ovs #(
    parameter int DATA_MAX = 9,
    parameter int OVS      = 16,
    parameter int DIV_W    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [DIV_W-1:0]    br_div,
    input  logic [3:0]          word_len,
    input  logic                parity_en,
    input  logic                parity_odd,
    input  logic                stop2,
    input  logic                rx_in,
    output logic [DATA_MAX-1:0] data_out,
    output logic                data_valid,
    input  logic                data_ready,
    output logic                parity_err,
    output logic                frame_err,
    output logic                overrun,
    output logic                break_det,
    output logic                busy
);

    localparam int SC_W = $clog2(OVS);

    // Sample-counter positions of the three mid-bit samples and the wrap point.
    localparam logic [SC_W-1:0] c_SC_S0   = SC_W'(OVS / 2 - 1);
    localparam logic [SC_W-1:0] c_SC_S1   = SC_W'(OVS / 2);
    localparam logic [SC_W-1:0] c_SC_VOTE = SC_W'(OVS / 2 + 1);
    localparam logic [SC_W-1:0] c_SC_LAST = SC_W'(OVS - 1);
    localparam logic [3:0]      c_WL_MIN  = 4'd5;
    localparam logic [3:0]      c_WL_MAX  = 4'(DATA_MAX);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_START    = 3'd1,
        S_DATA     = 3'd2,
        S_PARITY   = 3'd3,
        S_STOP     = 3'd4,
        S_BRK_WAIT = 3'd5
    } state_t;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic                rx_meta_q, rx_s_q;
    state_t              state_q, state_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [SC_W-1:0]     sc_q, sc_d;
    logic                smp0_q, smp0_d, smp1_q, smp1_d;
    logic [3:0]          bc_q, bc_d;
    logic [DATA_MAX-1:0] sh_q, sh_d;
    logic                pbit_q, pbit_d;
    logic                stop1_q, stop1_d;
    logic                stop_idx_q, stop_idx_d;
    logic [3:0]          wl_q, wl_d;
    logic                pen_q, pen_d, podd_q, podd_d, stop2_q, stop2_d;
    logic [DATA_MAX-1:0] dout_q, dout_d;
    logic                valid_q, valid_d;
    logic                perr_q, perr_d, ferr_q, ferr_d;
    logic                ovr_q, ovr_d, brk_q, brk_d;

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic [DIV_W-1:0] w_brd_m1;
    logic             w_tick, w_vote_tick, w_wrap, w_vote;
    logic             w_last_stop, w_first_stop, w_ferr, w_brk, w_par_err;
    logic [3:0]       w_wl_clamped;

    assign w_brd_m1    = (br_div == '0) ? '0 : br_div - DIV_W'(1);
    assign w_tick      = (state_q != S_IDLE) && (div_q == w_brd_m1);
    assign w_vote_tick = w_tick && (sc_q == c_SC_VOTE);
    assign w_wrap      = w_tick && (sc_q == c_SC_LAST);

    // Third sample is the live synchronised line on the vote tick.
    assign w_vote = (smp0_q & smp1_q) | (smp0_q & rx_s_q) | (smp1_q & rx_s_q);

    assign w_wl_clamped = (word_len < c_WL_MIN) ? c_WL_MIN :
                          (word_len > c_WL_MAX) ? c_WL_MAX : word_len;

    // Completion happens on the vote of the last stop bit; with two stop bits
    // the first stop value was stored earlier in stop1_q.
    assign w_last_stop  = w_vote_tick && (state_q == S_STOP) && (stop_idx_q || !stop2_q);
    assign w_first_stop = stop_idx_q ? stop1_q : w_vote;
    assign w_ferr       = !w_first_stop || (stop_idx_q && !w_vote);
    assign w_brk        = (sh_q == '0) && (!pen_q || !pbit_q) && !w_first_stop;
    assign w_par_err    = ((^sh_q) ^ pbit_q) != podd_q;

    // ------------------------------------------------------------------------
    // Next-state / datapath
    // ------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        sc_d       = sc_q;
        smp0_d     = smp0_q;
        smp1_d     = smp1_q;
        bc_d       = bc_q;
        sh_d       = sh_q;
        pbit_d     = pbit_q;
        stop1_d    = stop1_q;
        stop_idx_d = stop_idx_q;
        wl_d       = wl_q;
        pen_d      = pen_q;
        podd_d     = podd_q;
        stop2_d    = stop2_q;
        dout_d     = dout_q;
        valid_d    = valid_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        ovr_d      = ovr_q;
        brk_d      = brk_q;

        // Baud and sample counters only run while a frame is in progress,
        // so every frame starts phase-aligned to its own falling edge.
        if (state_q == S_IDLE) begin
            div_d = '0;
            sc_d  = '0;
        end else if (w_tick) begin
            div_d = '0;
            sc_d  = (sc_q == c_SC_LAST) ? '0 : sc_q + SC_W'(1);
            if (sc_q == c_SC_S0) smp0_d = rx_s_q;
            if (sc_q == c_SC_S1) smp1_d = rx_s_q;
        end else begin
            div_d = div_q + DIV_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (!rx_s_q) begin
                    state_d    = S_START;
                    wl_d       = w_wl_clamped;
                    pen_d      = parity_en;
                    podd_d     = parity_odd;
                    stop2_d    = stop2;
                    sh_d       = '0;
                    bc_d       = '0;
                    pbit_d     = 1'b0;
                    stop1_d    = 1'b1;
                    stop_idx_d = 1'b0;
                end
            end
            S_START: begin
                if (w_vote_tick && w_vote) begin
                    state_d = S_IDLE;       // glitch, not a real start bit
                end else if (w_wrap) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (w_vote_tick) begin
                    for (int i = 0; i < DATA_MAX; i++) begin
                        if (bc_q == 4'(i)) sh_d[i] = w_vote;
                    end
                end
                if (w_wrap) begin
                    if (bc_q == wl_q - 4'd1) begin
                        bc_d    = '0;
                        state_d = pen_q ? S_PARITY : S_STOP;
                    end else begin
                        bc_d = bc_q + 4'd1;
                    end
                end
            end
            S_PARITY: begin
                if (w_vote_tick) pbit_d = w_vote;
                if (w_wrap)      state_d = S_STOP;
            end
            S_STOP: begin
                if (w_last_stop) begin
                    // Leave on the vote tick so a following start bit is not missed.
                    state_d = w_brk ? S_BRK_WAIT : S_IDLE;
                end else if (w_vote_tick) begin
                    stop1_d    = w_vote;
                    stop_idx_d = 1'b1;
                end
            end
            S_BRK_WAIT: begin
                if (rx_s_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Output register: a new word wins over a simultaneous accept.
        if (w_last_stop) begin
            dout_d  = sh_q;
            valid_d = 1'b1;
            perr_d  = pen_q && w_par_err;
            ferr_d  = w_ferr;
            brk_d   = w_brk;
            ovr_d   = valid_q && !data_ready;
        end else if (valid_q && data_ready) begin
            valid_d = 1'b0;
            perr_d  = 1'b0;
            ferr_d  = 1'b0;
            brk_d   = 1'b0;
            ovr_d   = 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q  <= 1'b1;
            rx_s_q     <= 1'b1;
            state_q    <= S_IDLE;
            div_q      <= '0;
            sc_q       <= '0;
            smp0_q     <= 1'b0;
            smp1_q     <= 1'b0;
            bc_q       <= '0;
            sh_q       <= '0;
            pbit_q     <= 1'b0;
            stop1_q    <= 1'b0;
            stop_idx_q <= 1'b0;
            wl_q       <= c_WL_MIN;
            pen_q      <= 1'b0;
            podd_q     <= 1'b0;
            stop2_q    <= 1'b0;
            dout_q     <= '0;
            valid_q    <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            ovr_q      <= 1'b0;
            brk_q      <= 1'b0;
        end else begin
            rx_meta_q  <= rx_in;
            rx_s_q     <= rx_meta_q;
            state_q    <= state_d;
            div_q      <= div_d;
            sc_q       <= sc_d;
            smp0_q     <= smp0_d;
            smp1_q     <= smp1_d;
            bc_q       <= bc_d;
            sh_q       <= sh_d;
            pbit_q     <= pbit_d;
            stop1_q    <= stop1_d;
            stop_idx_q <= stop_idx_d;
            wl_q       <= wl_d;
            pen_q      <= pen_d;
            podd_q     <= podd_d;
            stop2_q    <= stop2_d;
            dout_q     <= dout_d;
            valid_q    <= valid_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            ovr_q      <= ovr_d;
            brk_q      <= brk_d;
        end
    end

    assign data_out   = dout_q;
    assign data_valid = valid_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign overrun    = ovr_q;
    assign break_det  = brk_q;
    assign busy       = (state_q != S_IDLE);

endmodule
`default_nettype wire
